// File: rtl/param_stream_loader_if.sv
// Stream and read-port bundle for param_stream_loader: beat handshake plus ROM-style read port.
interface param_stream_loader_if #(
    parameter int unsigned PRECISION_0 = 16,
    parameter int unsigned NELEM       = 4,
    parameter int unsigned AWIDTH      = 4,
    parameter int unsigned DWIDTH      = 64
);
    logic [PRECISION_0-1:0] data_in [NELEM];
    logic                   data_in_valid;
    logic                   data_in_ready;
    logic [AWIDTH-1:0]      rd_addr;
    logic                   rd_ce;
    logic [DWIDTH-1:0]      rd_data;

    modport master (
        output data_in, data_in_valid, rd_addr, rd_ce,
        input  data_in_ready, rd_data
    );

    modport slave (
        input  data_in, data_in_valid, rd_addr, rd_ce,
        output data_in_ready, rd_data
    );
endinterface

// File: rtl/param_stream_loader.sv
// Packs a valid/ready stream of parameter beats into a RAM and serves it via a 2-cycle read port.
// Define PARAM_STREAM_LOADER_CHECKSUM_EN to add a running XOR checksum of accepted beats.
module param_stream_loader #(
    parameter int unsigned PRECISION_0       = 16,
    parameter int unsigned PRECISION_1       = 3,
    parameter int unsigned TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned TENSOR_SIZE_DIM_1 = 1,
    parameter int unsigned PARALLELISM_DIM_0 = 4,
    parameter int unsigned PARALLELISM_DIM_1 = 1,
    parameter int unsigned DEPTH             = TENSOR_SIZE_DIM_0 * TENSOR_SIZE_DIM_1 /
                                               (PARALLELISM_DIM_0 * PARALLELISM_DIM_1),
    parameter int unsigned DWIDTH            = PRECISION_0 * PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    parameter int unsigned AWIDTH            = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    param_stream_loader_if.slave bus,
    output logic                 loaded,
    output logic [AWIDTH-1:0]    wr_count
`ifdef PARAM_STREAM_LOADER_CHECKSUM_EN
    ,
    output logic [DWIDTH-1:0]    checksum,
    output logic                 checksum_valid
`endif
);
    localparam int unsigned NELEM = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH-1:0] DepthA = AWIDTH'(DEPTH);
    localparam logic [AWIDTH-1:0] LastA  = AWIDTH'(DEPTH - 1);

    // Fractional bits only describe the fixed-point format; they must still fit in an element.
    if (PRECISION_1 > PRECISION_0) begin : gen_bad_frac
        $error("PRECISION_1 exceeds PRECISION_0");
    end

    typedef enum logic {StLoad, StLoaded} state_e;

    state_e            state;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] packed_beat;
    logic [DWIDTH-1:0] rd_stage1;
    logic [DWIDTH-1:0] rd_stage2;
    logic              accept;
    logic              rd_in_range;

    always_comb begin
        packed_beat = '0;
        for (int j = 0; j < NELEM; j++) begin
            packed_beat[PRECISION_0*j +: PRECISION_0] = bus.data_in[j];
        end
    end

    // Ready never depends on valid; clear blocks acceptance so it cannot race a beat.
    assign bus.data_in_ready = !rst && !clear && (state == StLoad);
    assign accept            = bus.data_in_valid && bus.data_in_ready;
    assign rd_in_range       = bus.rd_addr < DepthA;
    assign bus.rd_data       = rd_stage2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StLoad;
            wr_count <= '0;
            loaded   <= 1'b0;
`ifdef PARAM_STREAM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else if (clear) begin
            state    <= StLoad;
            wr_count <= '0;
            loaded   <= 1'b0;
`ifdef PARAM_STREAM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            unique case (state)
                StLoad: begin
                    if (accept) begin
                        wr_count <= wr_count + 1'b1;
`ifdef PARAM_STREAM_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ packed_beat;
`endif
                        if (wr_count == LastA) begin
                            state  <= StLoaded;
                            loaded <= 1'b1;
                        end
                    end
                end
                StLoaded: begin
                    wr_count <= DepthA;
                    loaded   <= 1'b1;
                end
                default: state <= StLoad;
            endcase
        end
    end

`ifdef PARAM_STREAM_LOADER_CHECKSUM_EN
    assign checksum_valid = loaded;
`endif

    // RAM contents survive reset and clear; only the count decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_count[IDXW-1:0]] <= packed_beat;
        end
    end

    // Non-blocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_stage1 <= '0;
            rd_stage2 <= '0;
        end else if (bus.rd_ce) begin
            rd_stage1 <= rd_in_range ? mem[bus.rd_addr[IDXW-1:0]] : '0;
            rd_stage2 <= rd_stage1;
        end
    end
endmodule
